font_loader: RTL and testbench

//  Write-side engine for font memory: consumes a host byte stream of glyph-load

---
 rtl/font_loader.sv | 105 ++++++++++
 tb/tb_font_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/font_loader.sv
// Glyph-load command engine: parses a host byte stream and drives the
// active-low font memory write port, one row byte per accepted DATA byte.
module font_loader #(
  parameter int         ADDR_W    = 12,
  parameter int         ROW_W     = 4,
  parameter logic [7:0] CMD_GLYPH = 8'h01,
  parameter logic [7:0] CMD_RANGE = 8'h02
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] GLYPH_CNT = CNT_W'(1 << ROW_W);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GIDX = 3'd1,
    S_GCNT = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic              range_mode;
  logic              accept;

  // Handshake: a byte moves on any rising edge where in_valid and in_ready
  // are both high; in_ready drops only during reset and the single DONE cycle.
  assign in_ready  = nrst & (state != S_DONE);
  assign accept    = in_valid & in_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && (in_data == CMD_GLYPH || in_data == CMD_RANGE))
                state_next = S_GIDX;
      S_GIDX: if (accept) state_next = range_mode ? S_GCNT : S_DATA;
      S_GCNT: if (accept) state_next = S_DATA;
      S_DATA: if (accept && cnt == CNT_W'(1)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= S_IDLE;
      addr       <= '0;
      cnt        <= '0;
      range_mode <= 1'b0;
      wr         <= 1'b1;
      wr_addr    <= '0;
      wr_data    <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_next;
      wr    <= 1'b1;
      err   <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (in_data == CMD_GLYPH) begin
              cnt        <= GLYPH_CNT;
              range_mode <= 1'b0;
            end else if (in_data == CMD_RANGE) begin
              range_mode <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          S_GIDX: addr <= {in_data, {ROW_W{1'b0}}};
          // n == 0 encodes a full 256-glyph run, i.e. the whole memory.
          S_GCNT: cnt <= (in_data == 8'd0) ? FULL_CNT
                                           : CNT_W'({in_data, {ROW_W{1'b0}}});
          S_DATA: begin
            wr      <= 1'b0;
            wr_addr <= addr;
            wr_data <= in_data;
            addr    <= addr + ADDR_W'(1);
            cnt     <= cnt - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_font_loader.sv
// Directed bench for font_loader: drives command byte streams and scores every
// write strobe against an expected {addr,data} queue.
module tb_font_loader;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, err;
  logic [2:0]  dbg_state;

  font_loader dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];
  int n_writes, n_done, n_err, n_not_ready, n_busy_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_writes = 0; n_done = 0; n_err = 0; n_not_ready = 0; n_busy_low = 0;
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (!in_ready) n_not_ready++;
      if (!busy) n_busy_low++;
      if (err) n_err++;
      if (done) begin
        n_done++;
        check("done_with_strobe", {31'd0, wr}, 32'd0);
        check("done_err_excl", {31'd0, err}, 32'd0);
      end
      if (!wr) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {20'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {20'd0, wr_addr}, {20'd0, e[19:8]});
          check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at a falling edge; the byte is taken at the rising edge
  // following the first falling edge where in_ready is high.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_glyph(input logic [7:0] g, input logic [7:0] base, input int max_gap);
    send_byte(8'h01, $urandom_range(0, max_gap));
    send_byte(g, $urandom_range(0, max_gap));
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({g, i[3:0], base + i[7:0]});
      send_byte(base + i[7:0], $urandom_range(0, max_gap));
    end
    #1;
  endtask

  task automatic check_glyph_result(input string tag);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_writes"}, n_writes, 16);
    check({tag, "_done"}, n_done, 1);
    check({tag, "_err"}, n_err, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_counts();

    // 1: reset values
    do_reset();
    check("rst_wr", {31'd0, wr}, 32'd1);
    check("rst_wr_addr", {20'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 2: single glyph, back-to-back bytes
    clear_counts();
    send_glyph(8'h41, 8'h00, 0);
    check("g41_done_now", {31'd0, done}, 32'd1);
    check("g41_last_addr", {20'd0, wr_addr}, 32'h41F);
    check_glyph_result("g41");
    @(negedge clk);
    check("g41_idle_busy", {31'd0, busy}, 32'd0);

    // 3: range of two glyphs across the address wrap
    clear_counts();
    send_byte(8'h02, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({12'hFF0 + i[11:0], i[7:0] ^ 8'hA5});
      send_byte(i[7:0] ^ 8'hA5, 0);
    end
    #1;
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_writes", n_writes, 32);
    check("wrap_done", n_done, 1);
    check("wrap_last_addr", {20'd0, wr_addr}, 32'h00F);
    @(negedge clk);

    // 4: n=0 loads the whole memory
    clear_counts();
    send_byte(8'h02, 0);
    n_busy_low = 0;
    n_not_ready = 0;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 4096; i++) begin
      exp_q.push_back({i[11:0], i[7:0] ^ i[11:4]});
      send_byte(i[7:0] ^ i[11:4], 0);
    end
    #1;
    check("full_queue_empty", exp_q.size(), 0);
    check("full_writes", n_writes, 4096);
    check("full_done", n_done, 1);
    check("full_done_now", {31'd0, done}, 32'd1);
    check("full_busy_low", n_busy_low, 0);
    check("full_not_ready", n_not_ready, 1);
    @(negedge clk);
    check("full_ready_after", {31'd0, in_ready}, 32'd1);

    // 5: unknown opcode, then a glyph with random gaps
    clear_counts();
    send_byte(8'h7E, 0);
    #1;
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_busy", {31'd0, busy}, 32'd0);
    check("bad_wr", {31'd0, wr}, 32'd1);
    @(negedge clk);
    check("bad_err_pulse", {31'd0, err}, 32'd0);
    check("bad_err_count", n_err, 1);
    check("bad_writes", n_writes, 0);
    clear_counts();
    send_glyph(8'h41, 8'h00, 3);
    check_glyph_result("gap");
    @(negedge clk);

    // 6: reset part-way through a glyph
    clear_counts();
    send_byte(8'h01, 0);
    send_byte(8'h42, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({8'h42, i[3:0], 8'hC0 + i[7:0]});
      send_byte(8'hC0 + i[7:0], 0);
    end
    #1;
    do_reset();
    check("abort_wr", {31'd0, wr}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_state", {29'd0, dbg_state}, 32'd0);
    check("abort_writes", n_writes, 5);
    check("abort_done", n_done, 0);
    check("abort_queue_empty", exp_q.size(), 0);
    nrst = 1'b1;
    @(negedge clk);
    clear_counts();
    send_glyph(8'h42, 8'hF0, 0);
    check_glyph_result("reload");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
